// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing one single-port data memory between four cores.
// It handles one transaction at a time and returns read data only to the core
// that won arbitration.
// Optional feature: define DM_ARB_FIXED_PRIO_EN to switch to fixed priority,
// where core 0 always wins.

module dm_arbiter #(
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned DATA_W  = 18,
  parameter int unsigned MEM_LAT = 1   // legal range 1..7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [3:0]            we,
  input  logic [4*ADDR_W-1:0]   addr_flat,
  input  logic [4*DATA_W-1:0]   wdata_flat,
  output logic [3:0]            gnt,
  output logic [3:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  busy,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [2:0] WaitInit = 3'(MEM_LAT - 1);

  state_e              state_q, state_d;
  logic [1:0]          win_q;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          wait_cnt_q;
  logic [DATA_W-1:0]   rdata_q;

  logic                win_valid;
  logic [1:0]          win;

`ifdef DM_ARB_FIXED_PRIO_EN
  // Fixed priority: the lowest set request index wins.
  always_comb begin
    win_valid = 1'b0;
    win       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req[i]) begin
        win_valid = 1'b1;
        win       = i[1:0];
      end
    end
  end
`else
  logic [1:0] rr_ptr_q;
  logic [1:0] cand;

  // Round-robin: search from rr_ptr+1; scan backwards so the first hit in
  // search order is the last assignment.
  always_comb begin
    win_valid = 1'b0;
    win       = 2'd0;
    cand      = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      cand = rr_ptr_q + k[1:0];
      if (req[cand]) begin
        win_valid = 1'b1;
        win       = cand;
      end
    end
  end

  // Pointer remembers the last winner; reset value 3 makes core 0 win first.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 2'd3;
    end else if (state_q == StIdle && win_valid) begin
      rr_ptr_q <= win;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; requests are only looked at in idle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (win_valid) state_d = StIssue;
      StIssue: state_d = we_q ? StIdle : StWait;
      StWait:  if (wait_cnt_q == 3'd0) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Transaction capture at arbitration, read latency count and read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      win_q      <= 2'd0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_cnt_q <= 3'd0;
      rdata_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (win_valid) begin
            win_q   <= win;
            we_q    <= we[win];
            addr_q  <= addr_flat[win*ADDR_W +: ADDR_W];
            wdata_q <= wdata_flat[win*DATA_W +: DATA_W];
          end
        end
        StIssue: wait_cnt_q <= WaitInit;
        StWait: begin
          if (wait_cnt_q == 3'd0) begin
            rdata_q <= mem_rdata;
          end else begin
            wait_cnt_q <= wait_cnt_q - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: strobes are decoded from state; address and data hold last value.
  always_comb begin
    mem_en    = (state_q == StIssue);
    mem_we    = mem_en & we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    gnt       = mem_en ? (4'b0001 << win_q) : 4'b0000;
    rvalid    = (state_q == StResp) ? (4'b0001 << win_q) : 4'b0000;
    rdata     = rdata_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with a small memory model whose read data is only valid in the exact
// cycle the latency allows.

module tb_dm_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req, we;
  logic [47:0] addr_flat;
  logic [71:0] wdata_flat;
  logic [3:0]  gnt, rvalid;
  logic [17:0] rdata;
  logic        busy, mem_en, mem_we;
  logic [11:0] mem_addr;
  logic [17:0] mem_wdata, mem_rdata;

  logic [3:0]  req3, we3;
  logic [47:0] addr3_flat;
  logic [71:0] wdata3_flat;
  logic [3:0]  gnt3, rvalid3;
  logic [17:0] rdata3;
  logic        busy3, m3_en, m3_we;
  logic [11:0] m3_addr;
  logic [17:0] m3_wdata, m3_rdata;

  logic        ld_en, ld_sel;
  logic [11:0] ld_addr;
  logic [17:0] ld_data;

  int n_checks = 0;
  int n_fail   = 0;

  dm_arbiter #(.ADDR_W(12), .DATA_W(18), .MEM_LAT(1)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr_flat(addr_flat),
    .wdata_flat(wdata_flat), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  dm_arbiter #(.ADDR_W(12), .DATA_W(18), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .req(req3), .we(we3), .addr_flat(addr3_flat),
    .wdata_flat(wdata3_flat), .gnt(gnt3), .rvalid(rvalid3), .rdata(rdata3),
    .busy(busy3), .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr),
    .mem_wdata(m3_wdata), .mem_rdata(m3_rdata)
  );

  // Memory model, latency 1.
  logic [17:0] mem [0:4095];
  logic [17:0] rd1_q;
  logic        rv1_q;
  always @(posedge clk) begin
    if (ld_en && !ld_sel) mem[ld_addr] <= ld_data;
    else if (mem_en && mem_we) mem[mem_addr] <= mem_wdata;
    rd1_q <= mem[mem_addr];
    rv1_q <= mem_en && !mem_we;
  end
  assign mem_rdata = rv1_q ? rd1_q : 18'h15555;

  // Memory model, latency 3 (read-only apart from preload).
  logic [17:0] mem3 [0:4095];
  logic [17:0] rd3_q [3];
  logic [2:0]  rv3_q;
  always @(posedge clk) begin
    if (ld_en && ld_sel) mem3[ld_addr] <= ld_data;
    rd3_q[0] <= mem3[m3_addr];
    rd3_q[1] <= rd3_q[0];
    rd3_q[2] <= rd3_q[1];
    rv3_q    <= {rv3_q[1:0], m3_en && !m3_we};
  end
  assign m3_rdata = rv3_q[2] ? rd3_q[2] : 18'h15555;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic mem_load(input logic sel, input logic [11:0] a, input logic [17:0] d);
    ld_en = 1'b1; ld_sel = sel; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 4'b0; we = 4'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait for the next grant, checking one-hotness every cycle.
  task automatic wait_gnt(input int budget, output logic [3:0] g);
    g = 4'b0;
    for (int c = 0; c < budget; c++) begin
      tick();
      check("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      if (gnt != 4'b0) begin
        g = gnt;
        break;
      end
    end
    if (g == 4'b0) check("gnt_timeout", 32'd0, 32'd1);
  endtask

  logic [3:0] g;
  logic       seen;

  initial begin
    rst = 1'b1; req = '0; we = '0; addr_flat = '0; wdata_flat = '0;
    req3 = '0; we3 = '0; addr3_flat = '0; wdata3_flat = '0;
    ld_en = 1'b0; ld_sel = 1'b0; ld_addr = '0; ld_data = '0;
    tick();
    mem_load(1'b0, 12'h010, 18'h2ABCD);
    mem_load(1'b0, 12'h123, 18'h1F0F0);
    mem_load(1'b1, 12'h0AB, 18'h05A5A);

    // Reset state.
    check("rst_gnt", gnt, 4'b0);
    check("rst_rvalid", rvalid, 4'b0);
    check("rst_rdata", rdata, 18'h0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_en", mem_en, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 12'h0);
    check("rst_mem_wdata", mem_wdata, 18'h0);
    rst = 1'b0;

    // 1: read from core 0, MEM_LAT=1.
    req = 4'b0001; we = 4'b0000; addr_flat[0 +: 12] = 12'h010;
    tick();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_mem_en", mem_en, 1'b1);
    check("t1_mem_we", mem_we, 1'b0);
    check("t1_mem_addr", mem_addr, 12'h010);
    check("t1_busy", busy, 1'b1);
    req = 4'b0;
    tick();
    check("t1_wait_rvalid", rvalid, 4'b0);
    check("t1_wait_gnt", gnt, 4'b0);
    tick();
    check("t1_rvalid", rvalid, 4'b0001);
    check("t1_rdata", rdata, 18'h2ABCD);
    tick();
    check("t1_idle_busy", busy, 1'b0);
    check("t1_idle_rvalid", rvalid, 4'b0);

    // 2: write from core 1.
    req = 4'b0010; we = 4'b0010;
    addr_flat[12 +: 12] = 12'h0FF; wdata_flat[18 +: 18] = 18'h3FFFF;
    tick();
    check("t2_gnt", gnt, 4'b0010);
    check("t2_mem_en", mem_en, 1'b1);
    check("t2_mem_we", mem_we, 1'b1);
    check("t2_mem_addr", mem_addr, 12'h0FF);
    check("t2_mem_wdata", mem_wdata, 18'h3FFFF);
    req = 4'b0; we = 4'b0;
    tick();
    check("t2_busy", busy, 1'b0);
    check("t2_mem_en_low", mem_en, 1'b0);
    check("t2_mem_we_low", mem_we, 1'b0);
    check("t2_wdata_hold", mem_wdata, 18'h3FFFF);
    check("t2_rdata_hold", rdata, 18'h2ABCD);
    check("t2_memword", mem[12'h0FF], 18'h3FFFF);

    // 3: all four request, each drops after its grant.
    do_reset();
    req = 4'b1111; we = 4'b1111;
    addr_flat = {12'h203, 12'h202, 12'h201, 12'h200};
    for (int i = 0; i < 4; i++) begin
      wait_gnt(10, g);
      check($sformatf("t3_gnt%0d", i), g, 4'b0001 << i);
      req = req & ~g;
    end
    we = 4'b0;

    // 4: cores 0 and 3 hold requests continuously.
    do_reset();
    req = 4'b1001; we = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      wait_gnt(10, g);
`ifdef DM_ARB_FIXED_PRIO_EN
      check($sformatf("t4_gnt%0d", i), g, 4'b0001);
`else
      check($sformatf("t4_gnt%0d", i), g, (i % 2 == 1) ? 4'b1000 : 4'b0001);
`endif
    end
    req = 4'b0; we = 4'b0;
    tick();
    tick();

    // 5: reset during the wait cycle of a read aborts it.
    do_reset();
    req = 4'b0001; we = 4'b0; addr_flat[0 +: 12] = 12'h010;
    tick();
    check("t5_gnt", gnt, 4'b0001);
    req = 4'b0;
    tick();
    check("t5_wait_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    check("t5_mem_en", mem_en, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_rvalid0", rvalid, 4'b0);
    rst = 1'b0;
    tick();
    check("t5_rvalid1", rvalid, 4'b0);
    req = 4'b1000; addr_flat[36 +: 12] = 12'h123;
    wait_gnt(10, g);
    check("t5_gnt3", g, 4'b1000);
    req = 4'b0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      tick();
      if (rvalid != 4'b0) begin
        seen = 1'b1;
        check("t5_rvalid3", rvalid, 4'b1000);
        check("t5_rdata", rdata, 18'h1F0F0);
      end
    end
    if (!seen) check("t5_rvalid_timeout", 32'd0, 32'd1);

    // 6: MEM_LAT=3 read from the third core (bit 2).
    req3 = 4'b0100; we3 = 4'b0; addr3_flat[24 +: 12] = 12'h0AB;
    tick();
    check("t6_gnt", gnt3, 4'b0100);
    req3 = 4'b0;
    for (int c = 2; c <= 4; c++) begin
      tick();
      check($sformatf("t6_rvalid_n%0d", c), rvalid3, 4'b0);
    end
    tick();
    check("t6_rvalid", rvalid3, 4'b0100);
    check("t6_rdata", rdata3, 18'h05A5A);
    tick();
    check("t6_busy", busy3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
